// File: rtl/game_pkg.sv
// Shared definitions for the music-game field engine and the LED matrix driver.
package game_pkg;

    localparam int FIELD_ROWS     = 16;
    localparam int FIELD_LANES    = 4;
    localparam int PERFECT_POINTS = 2;
    localparam int GOOD_POINTS    = 1;

    // One field row: bit l is lane l.
    typedef logic [FIELD_LANES-1:0] row_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } game_state_t;

    // Add two 16-bit values, clamping at all-ones.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Add two 8-bit values, clamping at all-ones.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/lane_judge.sv
// Per-lane hit judgement against the two bottom rows of the field.
module lane_judge (
    input  logic row_last_i,
    input  logic row_prev_i,
    input  logic key_i,
    output logic hit_o,
    output logic perfect_o,
    output logic clr_last_o,
    output logic clr_prev_o
);

    // The hit line has priority; the row above it only scores when the hit line is empty.
    always_comb begin
        hit_o      = 1'b0;
        perfect_o  = 1'b0;
        clr_last_o = 1'b0;
        clr_prev_o = 1'b0;
        if (key_i && row_last_i) begin
            hit_o      = 1'b1;
            perfect_o  = 1'b1;
            clr_last_o = 1'b1;
        end else if (key_i && row_prev_i) begin
            hit_o      = 1'b1;
            clr_prev_o = 1'b1;
        end else begin
            hit_o      = 1'b0;
        end
    end

endmodule

// File: rtl/block_field_engine.sv
// Falling-block field engine: scrolls the field, accepts spawn rows, judges key presses,
// and keeps score and combo.
module block_field_engine
    import game_pkg::*;
#(
    parameter int ROWS        = FIELD_ROWS,
    parameter int LANES       = FIELD_LANES,
    parameter int PERFECT_PTS = PERFECT_POINTS,
    parameter int GOOD_PTS    = GOOD_POINTS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             tick_step,
    input  logic             note_valid,
    input  logic [LANES-1:0] note_lanes,
    output logic             note_ready,
    input  logic             chart_end,
    input  logic [LANES-1:0] key_press,
    output logic [LANES-1:0] block_array [ROWS-1:0],
    output logic [LANES-1:0] hit_pulse,
    output logic [LANES-1:0] miss_pulse,
    output logic [15:0]      score,
    output logic [7:0]       combo,
    output logic             done
);

    game_state_t      state_q, state_d;
    logic [LANES-1:0] field_q [ROWS-1:0];
    logic [LANES-1:0] field_d [ROWS-1:0];
    logic [LANES-1:0] judged_s [ROWS-1:0];
    logic [LANES-1:0] buf_q, buf_d;
    logic             buf_valid_q, buf_valid_d;
    logic [LANES-1:0] hit_q, hit_d;
    logic [LANES-1:0] miss_q, miss_d;
    logic [15:0]      score_q, score_d;
    logic [7:0]       combo_q, combo_d;
    logic             done_q, done_d;

    logic             active_s;
    logic             transfer_s;
    logic             field_empty_s;
    logic [LANES-1:0] key_s;
    logic [LANES-1:0] hit_s, perfect_s, clr_last_s, clr_prev_s;
    logic [15:0]      pts_s;
    logic [7:0]       hit_cnt_s;

    assign active_s   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign key_s      = active_s ? key_press : '0;
    assign note_ready = (state_q == ST_RUN) && !buf_valid_q;
    assign transfer_s = note_valid && note_ready;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_judge u_judge (
            .row_last_i (field_q[ROWS-1][g]),
            .row_prev_i (field_q[ROWS-2][g]),
            .key_i      (key_s[g]),
            .hit_o      (hit_s[g]),
            .perfect_o  (perfect_s[g]),
            .clr_last_o (clr_last_s[g]),
            .clr_prev_o (clr_prev_s[g])
        );
    end

    // Sum this cycle's points and count the lanes that were hit.
    always_comb begin
        pts_s     = 16'd0;
        hit_cnt_s = 8'd0;
        for (int l = 0; l < LANES; l++) begin
            if (perfect_s[l]) begin
                pts_s = pts_s + 16'(PERFECT_PTS);
            end else if (hit_s[l]) begin
                pts_s = pts_s + 16'(GOOD_PTS);
            end else begin
                pts_s = pts_s;
            end
            if (hit_s[l]) begin
                hit_cnt_s = hit_cnt_s + 8'd1;
            end else begin
                hit_cnt_s = hit_cnt_s;
            end
        end
    end

    // Next-state logic: game FSM, hit clearing, scroll, spawn buffer, score and combo.
    always_comb begin
        state_d       = state_q;
        field_d       = field_q;
        buf_d         = buf_q;
        buf_valid_d   = buf_valid_q;
        hit_d         = '0;
        miss_d        = '0;
        score_d       = score_q;
        combo_d       = combo_q;
        field_empty_s = 1'b1;

        // Hits are removed from the pre-shift field so a hit block never scrolls on.
        judged_s           = field_q;
        judged_s[ROWS-1]   = field_q[ROWS-1] & ~clr_last_s;
        judged_s[ROWS-2]   = field_q[ROWS-2] & ~clr_prev_s;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    for (int i = 0; i < ROWS; i++) begin
                        field_d[i] = '0;
                    end
                    buf_d       = '0;
                    buf_valid_d = 1'b0;
                    score_d     = 16'd0;
                    combo_d     = 8'd0;
                end else begin
                    state_d     = state_q;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (tick_step) begin
                    miss_d     = field_q[ROWS-1] & ~clr_last_s;
                    field_d[0] = buf_valid_q ? buf_q : '0;
                    for (int i = 1; i < ROWS; i++) begin
                        field_d[i] = judged_s[i-1];
                    end
                end else begin
                    field_d    = judged_s;
                end

                // A transfer only happens with an empty buffer, so it may coincide with a tick
                // and simply lands in the buffer for the following tick.
                buf_valid_d = transfer_s ? 1'b1 : (tick_step ? 1'b0 : buf_valid_q);
                buf_d       = transfer_s ? note_lanes : buf_q;

                hit_d   = hit_s;
                score_d = sat_add16(score_q, pts_s);
                combo_d = (|miss_d) ? 8'd0 : sat_add8(combo_q, hit_cnt_s);

                if (state_q == ST_RUN) begin
                    state_d = chart_end ? ST_DRAIN : ST_RUN;
                end else begin
                    for (int i = 0; i < ROWS; i++) begin
                        field_empty_s = field_empty_s && (field_d[i] == '0);
                    end
                    state_d = (field_empty_s && !buf_valid_d) ? ST_DONE : ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < ROWS; i++) begin
                field_q[i] <= '0;
            end
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            hit_q       <= '0;
            miss_q      <= '0;
            score_q     <= 16'd0;
            combo_q     <= 8'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            field_q     <= field_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            score_q     <= score_d;
            combo_q     <= combo_d;
            done_q      <= done_d;
        end
    end

    assign block_array = field_q;
    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;
    assign score       = score_q;
    assign combo       = combo_q;
    assign done        = done_q;

endmodule

// File: tb/tb_block_field_engine.sv
// Directed bench for block_field_engine: a judge/scroll vector table plus hand-written
// sequences for lifetime, backpressure, drain, saturation and reset.
module tb_block_field_engine;

    logic       clk = 1'b0;
    logic       rst, start, tick_step, note_valid, chart_end;
    logic [3:0] note_lanes, key_press;
    logic       note_ready, done;
    logic [3:0] block_array [15:0];
    logic [3:0] hit_pulse, miss_pulse;
    logic [15:0] score;
    logic [7:0] combo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    block_field_engine dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .tick_step  (tick_step),
        .note_valid (note_valid),
        .note_lanes (note_lanes),
        .note_ready (note_ready),
        .chart_end  (chart_end),
        .key_press  (key_press),
        .block_array(block_array),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .score      (score),
        .combo      (combo),
        .done       (done)
    );

    typedef struct {
        logic [3:0]  r15;
        logic [3:0]  r14;
        logic [3:0]  press;
        logic        tk;
        logic [3:0]  hit;
        logic [3:0]  miss;
        logic [15:0] score;
        logic [7:0]  combo;
        logic [3:0]  n15;
        logic [3:0]  n14;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic spawn(input logic [3:0] lanes);
        note_valid = 1'b1;
        note_lanes = lanes;
        step();
        note_valid = 1'b0;
    endtask

    task automatic tick();
        tick_step = 1'b1;
        step();
        tick_step = 1'b0;
    endtask

    // Place pattern a at the hit line and pattern b one row above it.
    task automatic load_field(input logic [3:0] a, input logic [3:0] b);
        spawn(a);
        tick();
        spawn(b);
        tick();
        repeat (14) tick();
    endtask

    task automatic field_all_zero(output logic z);
        z = 1'b1;
        for (int r = 0; r < 16; r++) begin
            if (block_array[r] != 4'd0) z = 1'b0;
        end
    endtask

    initial begin
        logic       z;
        int         n;
        int         miss_seen;

        rst = 1'b0; start = 1'b0; tick_step = 1'b0; note_valid = 1'b0;
        chart_end = 1'b0; note_lanes = 4'd0; key_press = 4'd0;

        //            r15     r14     press   tk    hit     miss    score   combo n15     n14
        vecs[0] = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 4'b0001, 4'b0000, 16'd2, 8'd1, 4'b0000, 4'b0000};
        vecs[1] = '{4'b0011, 4'b0100, 4'b0111, 1'b1, 4'b0111, 4'b0000, 16'd5, 8'd3, 4'b0000, 4'b0000};
        vecs[2] = '{4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1000, 16'd0, 8'd0, 4'b0000, 4'b0000};
        vecs[3] = '{4'b0000, 4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000, 16'd1, 8'd1, 4'b0000, 4'b0000};
        vecs[4] = '{4'b0001, 4'b0000, 4'b0100, 1'b0, 4'b0000, 4'b0000, 16'd0, 8'd0, 4'b0001, 4'b0000};
        vecs[5] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0000, 16'd2, 8'd1, 4'b0000, 4'b0001};
        vecs[6] = '{4'b1001, 4'b0000, 4'b0001, 1'b1, 4'b0001, 4'b1000, 16'd2, 8'd0, 4'b0000, 4'b0000};
        vecs[7] = '{4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b1111, 4'b0000, 16'd8, 8'd4, 4'b1111, 4'b0000};
        vecs[8] = '{4'b0000, 4'b0101, 4'b0101, 1'b1, 4'b0101, 4'b0000, 16'd2, 8'd2, 4'b0000, 4'b0000};

        // Reset state.
        do_reset();
        field_all_zero(z);
        chk("rst_field", 32'(z), 32'd1);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_combo", 32'(combo), 32'd0);
        chk("rst_ready", 32'(note_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pulses", 32'({hit_pulse, miss_pulse}), 32'd0);

        // Judge / scroll table.
        for (int v = 0; v < 9; v++) begin
            do_reset();
            do_start();
            load_field(vecs[v].r15, vecs[v].r14);
            key_press = vecs[v].press;
            tick_step = vecs[v].tk;
            step();
            key_press = 4'd0;
            tick_step = 1'b0;
            chk($sformatf("v%0d_hit", v), 32'(hit_pulse), 32'(vecs[v].hit));
            chk($sformatf("v%0d_miss", v), 32'(miss_pulse), 32'(vecs[v].miss));
            chk($sformatf("v%0d_score", v), 32'(score), 32'(vecs[v].score));
            chk($sformatf("v%0d_combo", v), 32'(combo), 32'(vecs[v].combo));
            chk($sformatf("v%0d_row15", v), 32'(block_array[15]), 32'(vecs[v].n15));
            chk($sformatf("v%0d_row14", v), 32'(block_array[14]), 32'(vecs[v].n14));
            step();
            chk($sformatf("v%0d_pulse_end", v), 32'({hit_pulse, miss_pulse}), 32'd0);
        end

        // Block lifetime: spawned with tick 1, row 0 after tick 2, hit line after 17, miss at 18.
        do_reset();
        do_start();
        note_valid = 1'b1; note_lanes = 4'b1000; tick_step = 1'b1;
        step();
        note_valid = 1'b0; tick_step = 1'b0;
        chk("life_row0_t1", 32'(block_array[0]), 32'd0);
        tick();
        chk("life_row0_t2", 32'(block_array[0]), 32'b1000);
        repeat (15) tick();
        chk("life_row15_t17", 32'(block_array[15]), 32'b1000);
        chk("life_nomiss_t17", 32'(miss_pulse), 32'd0);
        tick();
        chk("life_miss_t18", 32'(miss_pulse), 32'b1000);
        chk("life_row15_t18", 32'(block_array[15]), 32'd0);
        chk("life_score", 32'(score), 32'd0);
        step();
        chk("life_miss_once", 32'(miss_pulse), 32'd0);

        // Handshake backpressure.
        do_reset();
        do_start();
        chk("bp_ready0", 32'(note_ready), 32'd1);
        note_valid = 1'b1; note_lanes = 4'b0011;
        step();
        chk("bp_ready_after_xfer", 32'(note_ready), 32'd0);
        note_lanes = 4'b0110;
        step();
        chk("bp_ready_held", 32'(note_ready), 32'd0);
        tick();
        chk("bp_ready_after_tick", 32'(note_ready), 32'd1);
        chk("bp_row0_a", 32'(block_array[0]), 32'b0011);
        step();
        note_valid = 1'b0;
        chk("bp_ready_after_b", 32'(note_ready), 32'd0);
        tick();
        chk("bp_row0_b", 32'(block_array[0]), 32'b0110);
        chk("bp_row1_a", 32'(block_array[1]), 32'b0011);
        tick();
        chk("bp_row0_empty", 32'(block_array[0]), 32'd0);
        chk("bp_row1_b", 32'(block_array[1]), 32'b0110);
        chk("bp_row2_a", 32'(block_array[2]), 32'b0011);

        // Drain to done through a miss.
        do_reset();
        do_start();
        load_field(4'b0001, 4'b0000);
        key_press = 4'b0001;
        step();
        key_press = 4'd0;
        spawn(4'b0100);
        repeat (4) tick();
        chk("drain_row3", 32'(block_array[3]), 32'b0100);
        chart_end = 1'b1;
        step();
        chart_end = 1'b0;
        note_valid = 1'b1; note_lanes = 4'b1111;
        chk("drain_ready", 32'(note_ready), 32'd0);
        step();
        chk("drain_ready2", 32'(note_ready), 32'd0);
        chk("drain_not_done", 32'(done), 32'd0);
        n = 0;
        miss_seen = 0;
        while (n < 40 && done !== 1'b1) begin
            tick();
            n++;
        end
        miss_seen = int'(miss_pulse);
        note_valid = 1'b0;
        chk("drain_ticks", 32'(n), 32'd13);
        chk("drain_miss", 32'(miss_seen), 32'b0100);
        chk("drain_done", 32'(done), 32'd1);
        key_press = 4'b1111; tick_step = 1'b1;
        step();
        key_press = 4'd0; tick_step = 1'b0;
        chk("done_score_hold", 32'(score), 32'd2);
        chk("done_no_hit", 32'(hit_pulse), 32'd0);
        chk("done_stays", 32'(done), 32'd1);
        do_start();
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_ready", 32'(note_ready), 32'd1);

        // Drain ending on a hit: combo survives into DONE and start clears it.
        do_reset();
        do_start();
        load_field(4'b0001, 4'b0000);
        chart_end = 1'b1;
        step();
        chart_end = 1'b0;
        chk("drain2_not_done", 32'(done), 32'd0);
        key_press = 4'b0001;
        step();
        key_press = 4'd0;
        chk("drain2_done", 32'(done), 32'd1);
        chk("drain2_combo", 32'(combo), 32'd1);
        chk("drain2_score", 32'(score), 32'd2);
        do_start();
        chk("drain2_restart_combo", 32'(combo), 32'd0);
        chk("drain2_restart_score", 32'(score), 32'd0);

        // Saturation: full rows every tick, all four lanes hit PERFECT from pair 17 on.
        do_reset();
        do_start();
        miss_seen = 0;
        for (int j = 1; j <= 16 + 8192; j++) begin
            spawn(4'b1111);
            key_press = (j >= 17) ? 4'b1111 : 4'b0000;
            tick_step = 1'b1;
            step();
            tick_step = 1'b0;
            key_press = 4'd0;
            if (miss_pulse != 4'd0) miss_seen++;
            if (j == 16 + 8191) chk("sat_score_fff8", 32'(score), 32'hFFF8);
        end
        chk("sat_score_ffff", 32'(score), 32'hFFFF);
        chk("sat_combo", 32'(combo), 32'd255);
        chk("sat_no_miss", 32'(miss_seen), 32'd0);
        chk("sat_row15_full", 32'(block_array[15]), 32'b1111);

        // Reset mid-scroll overrides every other input.
        rst = 1'b1; start = 1'b1; tick_step = 1'b1; key_press = 4'b1111;
        note_valid = 1'b1; note_lanes = 4'b1111;
        step();
        rst = 1'b0; start = 1'b0; tick_step = 1'b0; key_press = 4'd0; note_valid = 1'b0;
        field_all_zero(z);
        chk("mid_rst_field", 32'(z), 32'd1);
        chk("mid_rst_score", 32'(score), 32'd0);
        chk("mid_rst_combo", 32'(combo), 32'd0);
        chk("mid_rst_pulses", 32'({hit_pulse, miss_pulse}), 32'd0);
        chk("mid_rst_ready", 32'(note_ready), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        step();
        chk("mid_rst_idle", 32'(note_ready), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/block_field_engine.md
# block_field_engine

Game-field engine for the music game: holds the 4-lane × 16-row falling-block field, scrolls it one row per step tick, spawns new rows from the chart stage, and judges player key presses at the bottom hit line. It sits directly upstream of the LED matrix driver, which it feeds through `block_array`. It also reports per-lane hit/miss pulses, score and combo to the score display and sound stages.

## Interface
Parameters:
- `ROWS`, 16, field depth; row 0 = top, row `ROWS-1` = hit line.
- `LANES`, 4, number of lanes; bit *l* of a row = lane *l*.
- `PERFECT_PTS`, 2, points for a hit judged in row `ROWS-1`.
- `GOOD_PTS`, 1, points for a hit judged in row `ROWS-2`.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle pulse; begins or restarts a game.
- `tick_step` in 1: one-cycle pulse; one scroll step.
- `note_valid` in 1: chart stage offers a spawn row.
- `note_lanes` in `LANES`: lanes occupied in the offered spawn row; 0 is legal and means an empty row.
- `note_ready` out 1: engine accepts the spawn row this cycle.
- `chart_end` in 1: one-cycle pulse; the chart has no more notes.
- `key_press` in `LANES`: debounced one-cycle press pulses, one per lane.
- `block_array` out `[LANES-1:0] [ROWS-1:0]`: unpacked field, row-indexed, consumed by the LED driver.
- `hit_pulse` out `LANES`: one-cycle pulse per lane judged hit.
- `miss_pulse` out `LANES`: one-cycle pulse per lane whose block left the field unhit.
- `score` out 16: accumulated points, saturating.
- `combo` out 8: consecutive hits since the last miss, saturating.
- `done` out 1: high while in DONE.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DRAIN on `chart_end`.
  - DRAIN → DONE when the field is all zero and the spawn buffer is empty, evaluated after that cycle's update.
  - DONE → RUN on `start`.
  - `start` in RUN or DRAIN is ignored.
  - `chart_end` outside RUN is ignored.
- **Entering RUN** from IDLE or DONE clears the field, spawn buffer, `score` and `combo`.
- **Spawn buffer:** one-deep register plus a valid flag.
  - `note_ready` = (state == RUN) && !buf_valid.
  - A transfer occurs when `note_valid` && `note_ready`.
  - Upstream holds `note_lanes` stable while `note_valid` is high and `note_ready` is low.
- **Scroll:** on `tick_step` in RUN or DRAIN:
  - row[i+1] ← row[i] for each i.
  - row[0] ← buffer lanes if buf_valid, else 0; buf_valid is then cleared.
  - Bits that were set in row `ROWS-1` before the shift, and not cleared by a hit that same cycle, produce `miss_pulse`.
  - Outside RUN and DRAIN, `tick_step` is ignored.
- **Judge:** for each lane *l* with `key_press[l]` in RUN or DRAIN:
  - If row[`ROWS-1`][l] is set: PERFECT; clear that bit.
  - Else if row[`ROWS-2`][l] is set: GOOD; clear that bit.
  - Else: no effect (stray press).
  - Lanes are judged independently. Multiple hits in one cycle add their points together.
- **Score and combo:**
  - `score` += sum of points, saturating at 16'hFFFF.
  - `combo` += number of hits, saturating at 255.
  - Any `miss_pulse` bit in a cycle sets `combo` to 0. If hits and misses occur in the same cycle, the miss wins for `combo`; the hits still score.
- **Outside RUN/DRAIN:** `key_press` is ignored. In DONE, `score` and `combo` hold.

## Timing
- **Reset values:** state IDLE; `block_array` all 0; `note_ready`, `done` 0; `hit_pulse`, `miss_pulse` 0; `score`, `combo` 0. Reset applies mid-game on the next edge and overrides all other inputs.
- All outputs are registered.
  - `block_array` reflects a `tick_step` or a hit one cycle after it.
  - `hit_pulse` and `miss_pulse` are high exactly one cycle, the cycle after their cause.
  - `score` and `combo` update in that same cycle.
- **Key press and tick in the same cycle:** the judge uses the pre-shift field. A hit bit is cleared and does not shift. A hit in row `ROWS-1` therefore suppresses that lane's miss.
- **Spawn and tick in the same cycle:** a note transferred in the same cycle as `tick_step` (possible only when buf_valid was 0) lands in the buffer. It does not reach row 0 until the next tick.
- **Block lifetime:** a block spawned at tick N occupies row 0 after tick N+1 and row `ROWS-1` after tick N+`ROWS`. It misses at tick N+`ROWS`+1.
- `note_ready` is combinational from registered state. It drops to 0 in the cycle after a transfer.

## Structure
- **Shared package `game_pkg`:** `ROWS`, `LANES`, point constants, the state enum `game_state_t`, and a `row_t` typedef of `LANES` bits. The LED driver uses the same row typedef.
- **Sub-module `lane_judge`:** natural to use one instance per lane. It takes the two hit-line bits and the key press, and returns hit, perfect, and clear outputs. The score adder and FSM stay in the top module.

## Test plan
- **Basic PERFECT hit:** reset, `start`, spawn 4'b0001, 17 ticks, press lane 0 → `hit_pulse`=4'b0001, `score`=2, `combo`=1, row 15 lane 0 cleared.
- **Miss:** spawn 4'b1000, 18 ticks with no press → `miss_pulse`=4'b1000 the cycle after tick 18; `combo` 0; `score` unchanged.
- **Simultaneous hits and tick:** blocks in row 15 lanes 0 and 1 plus row 14 lane 2; press 4'b0111 in the same cycle as `tick_step` → `score` +5, `combo` +3, no `miss_pulse`, lane 2 not shifted.
- **Handshake backpressure:** hold `note_valid` for two notes within one step interval → second note waits with `note_ready`=0 until the tick consumes the buffer; no note is lost or duplicated.
- **Drain to done:** `chart_end` with one block at row 3 → `note_ready` stays 0; after the block leaves (miss), state goes DONE and `done`=1; `start` clears `score` and `combo`.
- **Saturation and reset:** preload `score`=16'hFFFE, score a PERFECT → 16'hFFFF; assert `rst` mid-scroll → all outputs 0 the next cycle, state IDLE.
